// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: default widths (matching the
// 4x4->8 multiplier it inverts) and the controller state encoding.
package seq_divider_pkg;

    localparam int DEF_N_W = 8;
    localparam int DEF_D_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int D_W = 4
) (
    input  logic [D_W-1:0] i_r,
    input  logic           i_bit,
    input  logic [D_W-1:0] i_divisor,
    output logic [D_W-1:0] o_r,
    output logic           o_q
);

    // One bit wider than the remainder so the shifted value cannot overflow.
    logic [D_W:0] w_trial;
    logic [D_W:0] w_div_ext;

    assign w_trial   = {i_r, i_bit};
    assign w_div_ext = {1'b0, i_divisor};
    assign o_q       = (w_trial >= w_div_ext);
    assign o_r       = o_q ? D_W'(w_trial - w_div_ext) : w_trial[D_W-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock, with a
// start/ready/valid handshake and a single-cycle divide-by-zero path.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N_W = DEF_N_W,
    parameter int D_W = DEF_D_W
) (
    input  logic           i_ck,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic [N_W-1:0] i_dividend,
    input  logic [D_W-1:0] i_divisor,
    output logic           o_ready,
    output logic           o_valid,
    output logic [N_W-1:0] o_quotient,
    output logic [D_W-1:0] o_remainder,
    output logic           o_div_by_zero
);

    localparam int CNT_W = $clog2(N_W);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [N_W-1:0]   r_shift;
    logic [D_W-1:0]   r_rem;
    logic [D_W-1:0]   r_divisor;
    logic [N_W-1:0]   r_quotient;
    logic [D_W-1:0]   r_remainder;
    logic             r_dbz;

    logic             w_ready;
    logic             w_valid;
    logic             w_accept;
    logic             w_zero_div;
    logic [D_W-1:0]   w_rem_next;
    logic             w_qbit;
    logic [N_W-1:0]   w_shift_next;

    assign w_accept     = i_start & w_ready;
    assign w_zero_div   = (i_divisor == '0);
    assign w_shift_next = {r_shift[N_W-2:0], w_qbit};

    div_step #(.D_W(D_W)) u_step (
        .i_r       (r_rem),
        .i_bit     (r_shift[N_W-1]),
        .i_divisor (r_divisor),
        .o_r       (w_rem_next),
        .o_q       (w_qbit)
    );

    always_ff @(posedge i_ck or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start)               w_state_next = w_zero_div ? S_DONE : S_RUN;
                else if (r_state == S_DONE) w_state_next = S_IDLE;
            end
            S_RUN:   if (r_cnt == '0) w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_ready = 1'b1;
            S_DONE:  begin w_ready = 1'b1; w_valid = 1'b1; end
            default: ;
        endcase
    end

    // r_shift holds the unconsumed dividend bits on the left and the
    // quotient bits produced so far on the right.
    always_ff @(posedge i_ck or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_rem       <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            if (w_zero_div) begin
                r_quotient  <= '1;
                r_remainder <= '0;
                r_dbz       <= 1'b1;
            end else begin
                r_shift   <= i_dividend;
                r_divisor <= i_divisor;
                r_rem     <= '0;
                r_cnt     <= CNT_W'(N_W - 1);
                r_dbz     <= 1'b0;
            end
        end else if (r_state == S_RUN) begin
            r_shift <= w_shift_next;
            r_rem   <= w_rem_next;
            r_cnt   <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_quotient  <= w_shift_next;
                r_remainder <= w_rem_next;
            end
        end
    end

    assign o_ready       = w_ready;
    assign o_valid       = w_valid;
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_dbz;

endmodule
